// File: rtl/spi_print_pkg.sv
// spi_print_pkg: shared FSM state type and link constants for the SPI print transmitter.
package spi_print_pkg;
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_e;
    localparam int SPI_BITS = 8;
endpackage

// File: rtl/spi_print_fifo.sv
// spi_print_fifo: synchronous FIFO with registered read data, valid the cycle after pop.
module spi_print_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] dout_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic wr, rd;
    assign full_o  = cnt_q == FULL_CNT;
    assign empty_o = cnt_q == '0;
    assign wr      = push_i && !full_o;
    assign rd      = pop_i && !empty_o;
    assign count_o = cnt_q;
    assign dout_o  = dout_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            if (wr) wr_q <= wr_q + 1'b1;
            if (rd) begin
                rd_q   <= rd_q + 1'b1;
                dout_q <= mem_q[rd_q];
            end
            cnt_q <= cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/spi_print_tx.sv
// spi_print_tx: buffered byte-stream debug transmitter, MSB-first on a two-wire SPI-style link.
// Define SPI_PRINT_TX_CS_EN to add an active-low spi_csb framing output with a minimum deassert gap.
module spi_print_tx
    import spi_print_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          spi_clk,
    output logic                          spi_mosi,
    output logic                          busy,
`ifdef SPI_PRINT_TX_CS_EN
    output logic                          spi_csb,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(SPI_BITS);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    state_e state_q, state_d;
    logic [SPI_BITS-1:0] shr_q, shr_d, dout;
    logic [BW-1:0] bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic clk_q, clk_d, have_q, have_d;
    logic pop, load, load_ok, last, full, empty;
`ifdef SPI_PRINT_TX_CS_EN
    logic csb_q, csb_d;
    logic [DW-1:0] gap_q, gap_d;
    assign load_ok = gap_q == '0;
    assign spi_csb = csb_q;
`else
    assign load_ok = 1'b1;
`endif
    spi_print_fifo #(.WIDTH(SPI_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .pop_i   (pop),
        .din_i   (in_data),
        .dout_o  (dout),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_cnt)
    );
    assign in_ready = !full;
    assign spi_clk  = clk_q;
    // The top bit of the shift register is the line value, so it holds after the last bit.
    assign spi_mosi = shr_q[SPI_BITS-1];
    // have_q marks a popped byte waiting in the FIFO read register; count it as in flight.
    assign busy     = state_q != IDLE || fifo_cnt != '0 || have_q;
    assign last     = bit_q == BW'(SPI_BITS - 1);
    assign pop      = !have_q && !empty && (state_q == IDLE || last);
    assign load     = have_q && ((state_q == IDLE && load_ok) ||
                                 (state_q == HIGH && div_q == '0 && last));
    always_comb begin
        state_d = state_q;
        shr_d   = shr_q;
        bit_d   = bit_q;
        div_d   = div_q;
        clk_d   = clk_q;
        have_d  = pop ? 1'b1 : have_q;
`ifdef SPI_PRINT_TX_CS_EN
        csb_d   = csb_q;
        gap_d   = (state_q == IDLE && gap_q != '0) ? gap_q - 1'b1 : gap_q;
`endif
        case (state_q)
            LOW: begin
                div_d = div_q - 1'b1;
                if (div_q == '0) begin
                    clk_d   = 1'b1;
                    div_d   = DIV_MAX;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                div_d = div_q - 1'b1;
                if (div_q == '0) begin
                    clk_d = 1'b0;
                    div_d = DIV_MAX;
                    if (!last) begin
                        shr_d   = {shr_q[SPI_BITS-2:0], 1'b0};
                        bit_d   = bit_q + 1'b1;
                        state_d = LOW;
                    end else if (!have_q) begin
                        state_d = IDLE;
`ifdef SPI_PRINT_TX_CS_EN
                        csb_d   = 1'b1;
                        gap_d   = DIV_MAX;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            shr_d   = dout;
            bit_d   = '0;
            div_d   = DIV_MAX;
            have_d  = 1'b0;
            state_d = LOW;
`ifdef SPI_PRINT_TX_CS_EN
            csb_d   = 1'b0;
`endif
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shr_q   <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            clk_q   <= 1'b0;
            have_q  <= 1'b0;
`ifdef SPI_PRINT_TX_CS_EN
            csb_q   <= 1'b1;
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            shr_q   <= shr_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            clk_q   <= clk_d;
            have_q  <= have_d;
`ifdef SPI_PRINT_TX_CS_EN
            csb_q   <= csb_d;
            gap_q   <= gap_d;
`endif
        end
    end
endmodule

// File: tb/tb_spi_print_tx.sv
// tb_spi_print_tx: scoreboard bench; a receiver model frames spi_mosi on spi_clk rises.
module tb_spi_print_tx;
    localparam int DEPTH = 8;
    localparam int DIV   = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_valid1 = 1'b0;
    logic [7:0] in_data = '0, in_data1 = '0;
    wire in_ready, spi_clk, spi_mosi, busy;
    wire in_ready1, spi_clk1, spi_mosi1, busy1;
    wire [3:0] fifo_cnt, fifo_cnt1;
`ifdef SPI_PRINT_TX_CS_EN
    wire spi_csb, spi_csb1;
`endif
    spi_print_tx #(.FIFO_DEPTH(DEPTH), .CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .busy(busy),
`ifdef SPI_PRINT_TX_CS_EN
        .spi_csb(spi_csb),
`endif
        .fifo_cnt(fifo_cnt)
    );
    spi_print_tx #(.FIFO_DEPTH(DEPTH), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .spi_clk(spi_clk1), .spi_mosi(spi_mosi1), .busy(busy1),
`ifdef SPI_PRINT_TX_CS_EN
        .spi_csb(spi_csb1),
`endif
        .fifo_cnt(fifo_cnt1)
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    logic [7:0] exp_q[$];
    string rx_str = "";
    logic clk_prev = 1'b0, mosi_prev = 1'b0, gap_en = 1'b0;
    logic [7:0] sh = '0;
    int cyc = 0, last_rise = -1, rises = 0, nb = 0;
`ifdef SPI_PRINT_TX_CS_EN
    int hi = 0;
    logic seen_low = 1'b0;
`endif
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            nb = 0;
            clk_prev = 1'b0;
            mosi_prev = 1'b0;
        end else begin
            if (spi_clk && !clk_prev) begin
                chk("setup", spi_mosi, mosi_prev);
                if (gap_en && last_rise >= 0) chk("rise_gap", cyc - last_rise, 2 * DIV);
`ifdef SPI_PRINT_TX_CS_EN
                chk("csb_low", spi_csb, 0);
`endif
                last_rise = cyc;
                rises++;
                sh = {sh[6:0], spi_mosi};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    rx_str = $sformatf("%s%c", rx_str, sh);
                    if (exp_q.size() == 0) chk("rx_extra", sh, 32'hFFFF_FFFF);
                    else chk("rx_byte", sh, exp_q.pop_front());
                end
            end
`ifdef SPI_PRINT_TX_CS_EN
            if (spi_csb) hi++;
            else begin
                if (hi > 0 && seen_low) chk("csb_gap", hi >= DIV, 1);
                hi = 0;
                seen_low = 1'b1;
            end
`endif
            clk_prev = spi_clk;
            mosi_prev = spi_mosi;
        end
    end
    logic c1_prev = 1'b0, m1_prev = 1'b0;
    int r1 = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (r1 >= 1 && r1 < 16) chk("d1_toggle", spi_clk1, !c1_prev);
            if (spi_clk1 && !c1_prev) begin
                chk("d1_bit", spi_mosi1, r1 < 8);
                chk("d1_setup", spi_mosi1, m1_prev);
                r1++;
            end
            c1_prev = spi_clk1;
            m1_prev = spi_mosi1;
        end
    end
    logic saw_full = 1'b0;
    task automatic push(input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        if (!in_ready) begin
            saw_full = 1'b1;
            chk("full_cnt", fifo_cnt, DEPTH);
        end
        while (!in_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) chk("push_timeout", 0, 1);
        else begin
            @(posedge clk);
            exp_q.push_back(d);
            #1;
        end
        in_valid = 1'b0;
    endtask
    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", n < 2000, 1);
    endtask
    initial begin
        int n, first;
        logic [7:0] msg[3] = '{8'h48, 8'h69, 8'h0A};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clk", spi_clk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_ready", in_ready, 1);
`ifdef SPI_PRINT_TX_CS_EN
        chk("rst_csb", spi_csb, 1);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        rises = 0;
        push(8'h48);
        chk("cnt_after_push", fifo_cnt, 1);
        n = 0;
        first = -1;
        while (busy && n < 200) begin
            if (spi_clk && first < 0) first = n;
            @(posedge clk); #1;
            n++;
        end
        chk("first_rise", first, 2 + DIV);
        chk("busy_fall", n, 2 + 16 * DIV);
        chk("end_clk_low", spi_clk, 0);
        chk("rises_1", rises, 8);
        rises = 0;
        last_rise = -1;
        gap_en = 1'b1;
        rx_str = "";
        foreach (msg[i]) push(msg[i]);
        wait_idle();
        gap_en = 1'b0;
        chk("rises_3", rises, 24);
        chk("hi_str", rx_str == "Hi\n", 1);
        rises = 0;
        for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
        wait_idle();
        chk("saw_full", saw_full, 1);
        chk("rises_10", rises, 80);
        rises = 0;
        push(8'hA5);
        n = 0;
        while (rises < 4 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bit4_reach", rises, 4);
        rst = 1'b1;
        #1;
        chk("arst_clk", spi_clk, 0);
        chk("arst_mosi", spi_mosi, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cnt", fifo_cnt, 0);
        chk("arst_ready", in_ready, 1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        rises = 0;
        push(8'h55);
        wait_idle();
        chk("rises_55", rises, 8);
        chk("d1_ready", in_ready1, 1);
        in_valid1 = 1'b1;
        in_data1 = 8'hFF;
        @(posedge clk); #1;
        in_data1 = 8'h00;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        n = 0;
        while (r1 < 16 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("d1_rises", r1, 16);
        chk("d1_idle", busy1, 0);
`ifdef SPI_PRINT_TX_CS_EN
        rises = 0;
        push(8'h41);
        wait_idle();
        chk("csb_idle", spi_csb, 1);
        push(8'h42);
        wait_idle();
        chk("rises_cs", rises, 16);
        chk("csb_end", spi_csb, 1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
